// File: rtl/dmem_bridge_if.sv
// ---------------------------------------------------------------------------
// dmem_bridge_if
// Bundles the memory-stage request/response signals and the memory-side
// request/grant/read-data handshake of the data-memory bridge.
//
// Core side (memory stage <-> bridge):
//   request  : access request from the memory stage
//   we_re    : 1 = store, 0 = load
//   mask     : byte-enable mask
//   addr     : byte address from the ALU
//   wdata    : lane-aligned store data
//   valid    : one-cycle access-complete pulse
//   rdata    : raw load word
//   stall    : hold the pipeline
//   err      : timeout flag, qualified by valid
// Memory side (bridge <-> data memory):
//   mem_req, mem_we, mem_mask, mem_addr, mem_wdata : request towards memory
//   mem_gnt    : memory accepted the request
//   mem_rvalid : read data valid
//   mem_rdata  : read word
//
// Modports:
//   slave  : the bridge itself
//   master : the environment (memory stage plus data memory)
// ---------------------------------------------------------------------------
interface dmem_bridge_if;
    logic        request;
    logic        we_re;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        valid;
    logic [31:0] rdata;
    logic        stall;
    logic        err;

    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_mask;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport slave (
        input  request, we_re, mask, addr, wdata,
        output valid, rdata, stall, err,
        output mem_req, mem_we, mem_mask, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport master (
        output request, we_re, mask, addr, wdata,
        input  valid, rdata, stall, err,
        input  mem_req, mem_we, mem_mask, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/dmem_bridge.sv
// ---------------------------------------------------------------------------
// dmem_bridge
// Converts a single-cycle load/store request from the memory stage into a
// request/grant/rvalid transaction on the data-memory port. The access is
// captured into holding registers so the memory side stays stable under
// grant backpressure even if the pipeline inputs move. A shared cycle
// counter aborts an access that spends TIMEOUT cycles in ISSUE+WAIT and
// reports it through err together with the valid pulse.
//
// Parameters:
//   TIMEOUT : cycles allowed in ISSUE+WAIT before abort (1..255)
// Ports:
//   clk : single clock, rising edge
//   rst : synchronous, active-high reset
//   bus : dmem_bridge_if.slave, core side and memory side signals
// ---------------------------------------------------------------------------
module dmem_bridge #(
    parameter int unsigned TIMEOUT = 32'd255
) (
    input  logic          clk,
    input  logic          rst,
    dmem_bridge_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Counter value seen on the last permitted waiting cycle.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 32'd1);

    state_t      state_r;
    state_t      state_next_s;

    logic [7:0]  cnt_r;
    logic        hold_we_r;
    logic [3:0]  hold_mask_r;
    logic [31:0] hold_addr_r;
    logic [31:0] hold_wdata_r;

    logic        valid_r;
    logic        err_r;
    logic        mem_req_r;
    logic [31:0] rdata_r;

    logic        latch_s;     // IDLE accepts a new request
    logic        capture_s;   // WAIT receives read data
    logic        timeout_s;   // access aborted this cycle
    logic        busy_s;      // in ISSUE or WAIT

    // Next-state decode plus the single-cycle event strobes.
    always_comb begin
        state_next_s = state_r;
        latch_s      = 1'b0;
        capture_s    = 1'b0;
        timeout_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.request) begin
                    latch_s      = 1'b1;
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // A grant on the last counted cycle still wins over the abort.
                if (bus.mem_gnt) begin
                    if (hold_we_r) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_WAIT;
                    end
                end else if (cnt_r == CNT_LAST) begin
                    timeout_s    = 1'b1;
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (bus.mem_rvalid) begin
                    capture_s    = 1'b1;
                    state_next_s = ST_DONE;
                end else if (cnt_r == CNT_LAST) begin
                    timeout_s    = 1'b1;
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                // A request still held high is picked up from IDLE next cycle.
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    assign busy_s = (state_r == ST_ISSUE) || (state_r == ST_WAIT);

    // Wait-cycle counter shared by ISSUE and WAIT; restarted on every new access.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= 8'd0;
        end else if (latch_s) begin
            cnt_r <= 8'd0;
        end else if (busy_s) begin
            cnt_r <= cnt_r + 8'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Holding registers: snapshot of the access, address word-aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_we_r    <= 1'b0;
            hold_mask_r  <= 4'd0;
            hold_addr_r  <= 32'd0;
            hold_wdata_r <= 32'd0;
        end else if (latch_s) begin
            hold_we_r    <= bus.we_re;
            hold_mask_r  <= bus.mask;
            hold_addr_r  <= {bus.addr[31:2], 2'b00};
            hold_wdata_r <= bus.wdata;
        end else begin
            hold_we_r    <= hold_we_r;
            hold_mask_r  <= hold_mask_r;
            hold_addr_r  <= hold_addr_r;
            hold_wdata_r <= hold_wdata_r;
        end
    end

    // State-qualified strobes registered from the next state, so they line up
    // exactly with the ISSUE and DONE cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_r <= 1'b0;
            valid_r   <= 1'b0;
        end else begin
            mem_req_r <= (state_next_s == ST_ISSUE);
            valid_r   <= (state_next_s == ST_DONE);
        end
    end

    // Error flag: cleared when an access enters ISSUE, set only by an abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (latch_s) begin
            err_r <= 1'b0;
        end else if (timeout_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    // Load data: updated by a load completion or zeroed by an abort; stores
    // leave it untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= 32'd0;
        end else if (capture_s) begin
            rdata_r <= bus.mem_rdata;
        end else if (timeout_s) begin
            rdata_r <= 32'd0;
        end else begin
            rdata_r <= rdata_r;
        end
    end

    // stall must react in the same cycle the request appears, so it is the
    // one combinational output; it is forced low while reset is asserted.
    assign bus.stall = ~rst & (((state_r == ST_IDLE) & bus.request) | busy_s);

    assign bus.valid     = valid_r;
    assign bus.err       = err_r;
    assign bus.rdata     = rdata_r;
    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = hold_we_r;
    assign bus.mem_mask  = hold_mask_r;
    assign bus.mem_addr  = hold_addr_r;
    assign bus.mem_wdata = hold_wdata_r;

endmodule

// File: tb/tb_dmem_bridge.sv
// ---------------------------------------------------------------------------
// tb_dmem_bridge
// Directed bench for dmem_bridge (TIMEOUT = 8). A table of per-cycle input
// and expected-output records covers store, delayed load, back-to-back loads
// and store-preserves-rdata; hand-written sequences cover grant
// backpressure, timeout, timeout-vs-grant priority and reset mid-WAIT.
// Inputs are driven on the falling edge and outputs sampled 1 time unit
// later, so each record describes one full clock cycle.
// ---------------------------------------------------------------------------
module tb_dmem_bridge;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    dmem_bridge_if bus ();

    dmem_bridge #(.TIMEOUT(32'd8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        req;
        logic        we;
        logic [3:0]  mask;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        gnt;
        logic        rv;
        logic [31:0] mrd;
        logic        e_valid;
        logic        e_stall;
        logic        e_err;
        logic        e_mem_req;
        logic [31:0] e_rdata;
        logic [31:0] e_mem_addr;
    } vec_t;

    vec_t vecs [26];

    function automatic vec_t mk(
        input logic rs, input logic rq, input logic we, input logic [3:0] mk_mask,
        input logic [31:0] ad, input logic [31:0] wd, input logic g, input logic r,
        input logic [31:0] md, input logic ev, input logic es, input logic ee,
        input logic emr, input logic [31:0] erd, input logic [31:0] ema);
        vec_t v;
        v.rst = rs; v.req = rq; v.we = we; v.mask = mk_mask; v.addr = ad; v.wdata = wd;
        v.gnt = g; v.rv = r; v.mrd = md; v.e_valid = ev; v.e_stall = es; v.e_err = ee;
        v.e_mem_req = emr; v.e_rdata = erd; v.e_mem_addr = ema;
        return v;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs on the falling edge, then let them settle.
    task automatic drive(input logic rs, input logic rq, input logic we, input logic [3:0] m,
                         input logic [31:0] ad, input logic [31:0] wd, input logic g,
                         input logic r, input logic [31:0] md);
        @(negedge clk);
        rst            = rs;
        bus.request    = rq;
        bus.we_re      = we;
        bus.mask       = m;
        bus.addr       = ad;
        bus.wdata      = wd;
        bus.mem_gnt    = g;
        bus.mem_rvalid = r;
        bus.mem_rdata  = md;
        #1;
    endtask

    task automatic idle_cycle();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.request = 1'b0; bus.we_re = 1'b0; bus.mask = 4'd0; bus.addr = 32'd0;
        bus.wdata = 32'd0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;
        repeat (2) @(posedge clk);

        //            rst   req   we    mask     addr          wdata         gnt   rv    mrdata        val   stl   err   mreq  rdata         mem_addr
        // reset with request high: stall stays low, everything cleared
        vecs[0]  = mk(1'b1, 1'b1, 1'b1, 4'b0100, 32'h0000_1006, 32'h00AB_0000, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0);
        // zero-wait store
        vecs[1]  = mk(1'b0, 1'b1, 1'b1, 4'b0100, 32'h0000_1006, 32'h00AB_0000, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0);
        vecs[2]  = mk(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        32'h0000_1004);
        vecs[3]  = mk(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_1004);
        vecs[4]  = mk(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_1004);
        // load: rvalid in ISSUE ignored, grant on 2nd ISSUE cycle, rvalid on 3rd WAIT cycle
        vecs[5]  = mk(1'b0, 1'b1, 1'b0, 4'b1111, 32'h0000_2000, 32'h0,         1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0000_1004);
        vecs[6]  = mk(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,         32'h0,         1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,       32'h0000_2000);
        vecs[7]  = mk(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        32'h0000_2000);
        vecs[8]  = mk(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0000_2000);
        vecs[9]  = mk(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0000_2000);
        vecs[10] = mk(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,         32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,       32'h0000_2000);
        vecs[11] = mk(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_2000);
        vecs[12] = mk(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_2000);
        // back-to-back loads, request held high through DONE
        vecs[13] = mk(1'b0, 1'b1, 1'b0, 4'b0011, 32'h0000_3002, 32'h0,         1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_2000);
        vecs[14] = mk(1'b0, 1'b1, 1'b0, 4'b0011, 32'h0000_3002, 32'h0,         1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0000_3000);
        vecs[15] = mk(1'b0, 1'b1, 1'b0, 4'b0011, 32'h0000_3002, 32'h0,         1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_3000);
        vecs[16] = mk(1'b0, 1'b1, 1'b0, 4'b0011, 32'h0000_4001, 32'h0,         1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 32'h0000_3000);
        vecs[17] = mk(1'b0, 1'b1, 1'b0, 4'b0011, 32'h0000_4001, 32'h0,         1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h0000_3000);
        vecs[18] = mk(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'h1234_5678, 32'h0000_4000);
        vecs[19] = mk(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,         32'h0,         1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h0000_4000);
        vecs[20] = mk(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'hCAFE_F00D, 32'h0000_4000);
        vecs[21] = mk(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'hCAFE_F00D, 32'h0000_4000);
        // store after loads: rvalid during ISSUE ignored, rdata preserved
        vecs[22] = mk(1'b0, 1'b1, 1'b1, 4'b1000, 32'h0000_500C, 32'hEE00_0000, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'hCAFE_F00D, 32'h0000_4000);
        vecs[23] = mk(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,         32'h0,         1'b1, 1'b1, 32'h5555_5555, 1'b0, 1'b1, 1'b0, 1'b1, 32'hCAFE_F00D, 32'h0000_500C);
        vecs[24] = mk(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'hCAFE_F00D, 32'h0000_500C);
        vecs[25] = mk(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'hCAFE_F00D, 32'h0000_500C);

        for (int i = 0; i < 26; i++) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].we, vecs[i].mask, vecs[i].addr,
                  vecs[i].wdata, vecs[i].gnt, vecs[i].rv, vecs[i].mrd);
            chk1 ($sformatf("row%0d valid", i),    bus.valid,    vecs[i].e_valid);
            chk1 ($sformatf("row%0d stall", i),    bus.stall,    vecs[i].e_stall);
            chk1 ($sformatf("row%0d err", i),      bus.err,      vecs[i].e_err);
            chk1 ($sformatf("row%0d mem_req", i),  bus.mem_req,  vecs[i].e_mem_req);
            chk32($sformatf("row%0d rdata", i),    bus.rdata,    vecs[i].e_rdata);
            chk32($sformatf("row%0d mem_addr", i), bus.mem_addr, vecs[i].e_mem_addr);
        end
        chk1 ("store mem_we", bus.mem_we, 1'b1);
        chk32("store mem_wdata", bus.mem_wdata, 32'hEE00_0000);

        // Grant backpressure: 5 cycles without grant, inputs wander meanwhile.
        drive(1'b0, 1'b1, 1'b1, 4'b0101, 32'h0000_6007, 32'hA5A5_A5A5, 1'b0, 1'b0, 32'h0);
        chk1("bp request stall", bus.stall, 1'b1);
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 1'b0, (k % 2 == 0) ? 1'b0 : 1'b1, 4'(k), 32'h0000_9000 + 32'(k),
                  32'h0000_0100 * 32'(k), (k == 5) ? 1'b1 : 1'b0, 1'b0, 32'h0);
            chk1 ($sformatf("bp%0d mem_req", k),   bus.mem_req,   1'b1);
            chk1 ($sformatf("bp%0d mem_we", k),    bus.mem_we,    1'b1);
            chk32($sformatf("bp%0d mem_mask", k),  32'(bus.mem_mask), 32'h5);
            chk32($sformatf("bp%0d mem_addr", k),  bus.mem_addr,  32'h0000_6004);
            chk32($sformatf("bp%0d mem_wdata", k), bus.mem_wdata, 32'hA5A5_A5A5);
            chk1 ($sformatf("bp%0d stall", k),     bus.stall,     1'b1);
            chk1 ($sformatf("bp%0d valid", k),     bus.valid,     1'b0);
        end
        idle_cycle();
        chk1("bp done valid", bus.valid, 1'b1);
        chk1("bp done err", bus.err, 1'b0);
        chk1("bp done mem_req", bus.mem_req, 1'b0);

        // Timeout: load never granted, aborts after 8 ISSUE cycles.
        drive(1'b0, 1'b1, 1'b0, 4'b1111, 32'h0000_7000, 32'h0, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 8; k++) begin
            idle_cycle();
            chk1($sformatf("to%0d mem_req", k), bus.mem_req, 1'b1);
            chk1($sformatf("to%0d valid", k),   bus.valid,   1'b0);
        end
        idle_cycle();
        chk1 ("to done valid", bus.valid, 1'b1);
        chk1 ("to done err", bus.err, 1'b1);
        chk32("to done rdata", bus.rdata, 32'h0);
        chk1 ("to done stall", bus.stall, 1'b0);
        chk1 ("to done mem_req", bus.mem_req, 1'b0);
        idle_cycle();
        chk1("to single pulse", bus.valid, 1'b0);

        // Grant on the timeout cycle wins: load completes normally.
        drive(1'b0, 1'b1, 1'b0, 4'b1111, 32'h0000_7100, 32'h0, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, (k == 7) ? 1'b1 : 1'b0, 1'b0, 32'h0);
            chk1($sformatf("pri%0d mem_req", k), bus.mem_req, 1'b1);
            chk1($sformatf("pri%0d err", k),     bus.err,     1'b0);
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h0BAD_F00D);
        chk1("pri wait stall", bus.stall, 1'b1);
        chk1("pri wait valid", bus.valid, 1'b0);
        idle_cycle();
        chk1 ("pri done valid", bus.valid, 1'b1);
        chk1 ("pri done err", bus.err, 1'b0);
        chk32("pri done rdata", bus.rdata, 32'h0BAD_F00D);

        // Normal store after the abort: err stays clear, rdata untouched.
        drive(1'b0, 1'b1, 1'b1, 4'b0001, 32'h0000_7204, 32'h0000_00FF, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h0);
        chk1("st2 issue err", bus.err, 1'b0);
        chk1("st2 issue mem_req", bus.mem_req, 1'b1);
        idle_cycle();
        chk1 ("st2 done valid", bus.valid, 1'b1);
        chk1 ("st2 done err", bus.err, 1'b0);
        chk32("st2 done rdata", bus.rdata, 32'h0BAD_F00D);

        // Reset in WAIT, then a late rvalid must be discarded.
        drive(1'b0, 1'b1, 1'b0, 4'b1111, 32'h0000_8000, 32'h0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h0);
        chk1("rw issue mem_req", bus.mem_req, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0);
        chk1("rw reset stall", bus.stall, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFF);
            chk1 ($sformatf("rw%0d valid", k),    bus.valid,    1'b0);
            chk32($sformatf("rw%0d rdata", k),    bus.rdata,    32'h0);
            chk1 ($sformatf("rw%0d stall", k),    bus.stall,    1'b0);
            chk1 ($sformatf("rw%0d mem_req", k),  bus.mem_req,  1'b0);
            chk32($sformatf("rw%0d mem_addr", k), bus.mem_addr, 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
